program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Byte-stream writer that fills the pipelined MIPS core's instruction and data memories through the core's load port: instruction, instructionAddress, data, dataAddress, writeEnable.
- The core is the reader on this port. It writes both memories on every writeEnable rising edge, so each load frame carries one instruction word and one data word for a shared 7-bit index.
- Sits between a host byte source (UART/bench) and the core; asserts load_done when the program image is complete.

Parameters:
- ADDR_W, 7, memory index width; the core has 128 entries.
- WORD_W, 32, instruction/data word width; fixed at 4 bytes per word.
- WE_HIGH_CYCLES, 2, number of cycles writeEnable is held high per frame (minimum 1).
- TIMEOUT_CYCLES, 1024, maximum idle cycles allowed between bytes inside a frame.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_byte  in  8  stream byte.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid & in_ready.
- instruction  out  32  instruction word to the core.
- instructionAddress  out  7  instruction memory index.
- data  out  32  data word to the core.
- dataAddress  out  7  data memory index; always equals instructionAddress.
- writeEnable  out  1  write strobe to the core; the core acts on its rising edge.
- load_done  out  1  sticky flag: end marker received.
- frame_err  out  1  sticky flag: a frame was aborted.
- frame_count  out  8  committed frames; saturates at 255.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces every output to 0 except in_ready, which is 1 in the first cycle after reset. Reset aborts any frame in progress, including mid-strobe: writeEnable drops the next cycle.
- Frame format:
  - header byte: bit7=1 means load frame, with bits6:0 as the address; bit7=0 is the end marker.
  - 4 instruction bytes, MSB first.
  - 4 data bytes, MSB first.
- FSM states: IDLE, INSTR (byte counter 0..3), DATA (byte counter 0..3), [CSUM], SETUP, STROBE, RECOVER, DONE.
- IDLE, in_ready=1:
  - header with bit7=1: latch address, go to INSTR.
  - header with bit7=0: set load_done, go to DONE.
- INSTR/DATA, in_ready=1: shift each accepted byte into an internal assembly register. After the 4th DATA byte, go to SETUP (or CSUM if the optional feature is enabled).
- SETUP, in_ready=0:
  - Copy the assembled words and address onto instruction/data/instructionAddress/dataAddress.
  - writeEnable stays 0, so outputs are stable for at least 1 cycle before the strobe rises.
- STROBE, in_ready=0: writeEnable=1 for exactly WE_HIGH_CYCLES cycles.
- RECOVER, in_ready=0:
  - writeEnable=0 for 1 cycle while outputs are still held, guaranteeing a low phase before the next rising edge.
  - frame_count increments, saturating at 255. Then go to IDLE.
- Output holding: address/word outputs change only in SETUP. They hold their value otherwise, including after a frame abort.
- Inter-byte timeout:
  - In INSTR/DATA/CSUM, a counter counts cycles with no accepted byte and resets on each accept.
  - When the counter reaches TIMEOUT_CYCLES: abort the frame, set frame_err, return to IDLE. No write occurs, and the partial words are discarded.
- DONE: in_ready=0, load_done=1, writeEnable=0 until reset.
- Boundaries:
  - address 0x7F is valid.
  - back-to-back frames require no gap on the input; the source simply sees in_ready low for WE_HIGH_CYCLES+2 cycles.
  - in_valid held high during in_ready=0 causes no transfer.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - One extra byte follows the data bytes, accepted in state CSUM.
  - The expected value is the XOR of the header and all 8 payload bytes.
  - Match: proceed to SETUP.
  - Mismatch: set frame_err, perform no write, leave frame_count unchanged, return to IDLE.
  - The timeout also applies in CSUM.
- Not defined: no CSUM state; the frame is 9 bytes; frame_err is driven only by timeout.

Test Plan:
- Reset, then send 0x85, 20 22 18 20, 00 00 00 0A -> instruction=0x20221820, data=0x0000000A, both addresses=5; writeEnable high 2 cycles; frame_count=1.
- Two frames back-to-back (addresses 0x00 and 0x7F) with in_valid held high -> two writeEnable pulses separated by ≥1 low cycle; outputs stable across each pulse; frame_count=2.
- Send 0x83 and 2 instruction bytes, then idle for 1024 cycles -> frame_err=1, no writeEnable pulse, outputs unchanged, in_ready=1.
- Send end marker 0x00 -> load_done=1, in_ready=0; later bytes are ignored; rst_n low for 1 cycle clears all flags and outputs.
- Assert rst_n=0 during the STROBE cycle -> writeEnable=0 next cycle, frame_count=0, FSM in IDLE.
- With LOADER_CHECKSUM_EN, send frame 0x81, 00×4, 00×3, 01, checksum 0x80 -> written. Resend with checksum 0x81 -> frame_err=1, no write.

Source files
------------

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Turns a host byte stream into write frames for the pipelined MIPS core's
// instruction and data memories. Each load frame is a header byte
// (bit7=1, bits6:0 = shared memory index), four instruction bytes and four
// data bytes, both MSB first. A header with bit7=0 ends the image and sets
// load_done. The core writes both memories on every rising writeEnable, so
// words and index are presented one cycle ahead of the strobe. After the
// strobe they are held for one more low cycle.
//
// Optional build macro: LOADER_CHECKSUM_EN. When it is defined, a ninth
// payload byte follows the data bytes. That byte must equal the XOR of the
// header and the eight payload bytes, otherwise the frame is dropped and
// frame_err is set.
//
// Ports
//   clk                 system clock, rising edge
//   rst_n               synchronous active-low reset
//   in_byte[7:0]        stream byte
//   in_valid            in_byte valid
//   in_ready            byte accepted when in_valid & in_ready
//   instruction[31:0]   instruction word to the core
//   instructionAddress  instruction memory index
//   data[31:0]          data word to the core
//   dataAddress         data memory index (always equals instructionAddress)
//   writeEnable         write strobe; the core acts on its rising edge
//   load_done           sticky: end marker received
//   frame_err           sticky: a frame was aborted
//   frame_count[7:0]    committed frames, saturating at 255
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int ADDR_W         = 7,
    parameter int WORD_W         = 32,
    parameter int WE_HIGH_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] instruction,
    output logic [ADDR_W-1:0] instructionAddress,
    output logic [WORD_W-1:0] data,
    output logic [ADDR_W-1:0] dataAddress,
    output logic              writeEnable,
    output logic              load_done,
    output logic              frame_err,
    output logic [7:0]        frame_count
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WE_W = $clog2(WE_HIGH_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WE_W-1:0] WE_LAST = WE_W'(WE_HIGH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INSTR,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_SETUP,
        S_STROBE,
        S_RECOVER,
        S_DONE
    } state_t;

    state_t            state_q;
    logic              in_ready_q;
    logic [1:0]        byte_cnt_q;
    logic [WE_W-1:0]   we_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] instr_asm_q;
    logic [WORD_W-1:0] data_asm_q;
    logic [WORD_W-1:0] instr_q;
    logic [WORD_W-1:0] data_q;
    logic [ADDR_W-1:0] waddr_q;
    logic              we_q;
    logic              load_done_q;
    logic              frame_err_q;
    logic [7:0]        frame_count_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic              accept;
    logic              in_frame;
    logic              timed_out;
    logic [WORD_W-1:0] instr_asm_d;
    logic [WORD_W-1:0] data_asm_d;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        accept      = in_valid & in_ready_q;
        in_frame    = 1'b0;
        instr_asm_d = {instr_asm_q[WORD_W-9:0], in_byte};
        data_asm_d  = {data_asm_q[WORD_W-9:0], in_byte};
        if (state_q == S_INSTR || state_q == S_DATA) in_frame = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (state_q == S_CSUM) in_frame = 1'b1;
`endif
        timed_out = in_frame & ~accept & (to_cnt_q == TO_LAST);
    end

    // NOTE: reset is sampled only on the clock edge (synchronous), so rst_n
    // appears as an ordinary priority branch, not in the sensitivity list.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the values from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b1;
            byte_cnt_q    <= '0;
            we_cnt_q      <= '0;
            to_cnt_q      <= '0;
            addr_q        <= '0;
            instr_asm_q   <= '0;
            data_asm_q    <= '0;
            instr_q       <= '0;
            data_q        <= '0;
            waddr_q       <= '0;
            we_q          <= 1'b0;
            load_done_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            // Idle-gap counter, live only while a frame is being received.
            if (in_frame) to_cnt_q <= accept ? '0 : to_cnt_q + 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        to_cnt_q   <= '0;
                        byte_cnt_q <= '0;
                        if (in_byte[7]) begin
                            addr_q  <= in_byte[ADDR_W-1:0];
                            state_q <= S_INSTR;
`ifdef LOADER_CHECKSUM_EN
                            csum_q  <= in_byte;
`endif
                        end else begin
                            load_done_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_INSTR: begin
                    if (accept) begin
                        instr_asm_q <= instr_asm_d;
                        byte_cnt_q  <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_q      <= csum_q ^ in_byte;
`endif
                        if (byte_cnt_q == 2'd3) state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        data_asm_q <= data_asm_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_q     <= csum_q ^ in_byte;
                        if (byte_cnt_q == 2'd3) state_q <= S_CSUM;
`else
                        // Outputs load on entry to SETUP so they are stable
                        // for the whole SETUP cycle before the strobe rises.
                        if (byte_cnt_q == 2'd3) begin
                            instr_q    <= instr_asm_q;
                            data_q     <= data_asm_d;
                            waddr_q    <= addr_q;
                            in_ready_q <= 1'b0;
                            state_q    <= S_SETUP;
                        end
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        if (in_byte == csum_q) begin
                            instr_q    <= instr_asm_q;
                            data_q     <= data_asm_q;
                            waddr_q    <= addr_q;
                            in_ready_q <= 1'b0;
                            state_q    <= S_SETUP;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                end
`endif
                S_SETUP: begin
                    we_q     <= 1'b1;
                    we_cnt_q <= '0;
                    state_q  <= S_STROBE;
                end
                S_STROBE: begin
                    if (we_cnt_q == WE_LAST) begin
                        we_q    <= 1'b0;
                        state_q <= S_RECOVER;
                    end else begin
                        we_cnt_q <= we_cnt_q + 1'b1;
                    end
                end
                S_RECOVER: begin
                    if (frame_count_q != 8'hFF) frame_count_q <= frame_count_q + 8'd1;
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                S_DONE: begin
                    in_ready_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // An expired gap aborts the frame; placed last so it overrides
            // the state update above. Partial words are simply abandoned.
            if (timed_out) begin
                frame_err_q <= 1'b1;
                to_cnt_q    <= '0;
                state_q     <= S_IDLE;
            end
        end
    end

    assign in_ready           = in_ready_q;
    assign instruction        = instr_q;
    assign data               = data_q;
    assign instructionAddress = waddr_q;
    assign dataAddress        = waddr_q;
    assign writeEnable        = we_q;
    assign load_done          = load_done_q;
    assign frame_err          = frame_err_q;
    assign frame_count        = frame_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: random and directed frames, compared against a
// queue-based model of the expected memory writes and flag values.
module tb_program_loader;

    localparam int WE_HIGH = 2;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction;
    logic [6:0]  instructionAddress;
    logic [31:0] data;
    logic [6:0]  dataAddress;
    logic        writeEnable;
    logic        load_done;
    logic        frame_err;
    logic [7:0]  frame_count;

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .instruction(instruction),
        .instructionAddress(instructionAddress), .data(data),
        .dataAddress(dataAddress), .writeEnable(writeEnable),
        .load_done(load_done), .frame_err(frame_err), .frame_count(frame_count)
    );

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] instr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  exp_fc = 0;
    bit  exp_err = 0;
    bit  exp_done = 0;
    bit  bubbles = 0;
    wr_t last_wr = '0;

    // Strobe monitor: records each write at its rising edge and checks the
    // setup/hold/pulse-width contract of the load port.
    initial begin
        bit          prev_we = 0;
        int          hi = 0;
        wr_t         prev_o = '0;
        wr_t         held = '0;
        wr_t         cur;
        forever begin
            @(negedge clk);
            cur = '{instructionAddress, instruction, data};
            if (!rst_n) begin
                prev_we = 0;
                hi = 0;
            end else begin
                if (writeEnable && !prev_we) begin
                    vectors++;
                    if (dataAddress !== instructionAddress) begin
                        miscompares++;
                        $display("FAIL addr_equal dataAddress=%h instructionAddress=%h", dataAddress, instructionAddress);
                    end
                    vectors++;
                    if (cur !== prev_o) begin
                        miscompares++;
                        $display("FAIL setup_stable at_rise=%h cycle_before=%h", cur, prev_o);
                    end
                    obs_q.push_back(cur);
                    held = cur;
                    hi = 1;
                end else if (writeEnable && prev_we) begin
                    hi++;
                    vectors++;
                    if (cur !== held) begin
                        miscompares++;
                        $display("FAIL strobe_stable got=%h want=%h", cur, held);
                    end
                end else if (!writeEnable && prev_we) begin
                    vectors++;
                    if (hi != WE_HIGH) begin
                        miscompares++;
                        $display("FAIL we_width got=%0d want=%0d", hi, WE_HIGH);
                    end
                    vectors++;
                    if (cur !== held) begin
                        miscompares++;
                        $display("FAIL recover_hold got=%h want=%h", cur, held);
                    end
                end
                prev_we = writeEnable;
            end
            prev_o = cur;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
        exp_fc = 0;
        exp_err = 0;
        exp_done = 0;
        last_wr = '0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        if (bubbles) begin
            int gap = $urandom_range(0, 2);
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) step();
            end
        end
        in_byte = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1;
            step();
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_byte byte=%h in_ready stayed low", b);
        end
    endtask

    // Sends one frame; the model records the write the frame should cause.
    task automatic send_frame(input logic [6:0] a, input logic [31:0] ins,
                              input logic [31:0] dat, input bit good);
        logic [7:0] bytes [9];
        logic [7:0] cs = 8'h00;
        bytes[0] = {1'b1, a};
        for (int i = 0; i < 4; i++) begin
            bytes[1+i] = ins[31-8*i -: 8];
            bytes[5+i] = dat[31-8*i -: 8];
        end
        for (int i = 0; i < 9; i++) begin
            cs ^= bytes[i];
            send_byte(bytes[i]);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(good ? cs : (cs ^ 8'h01));
`endif
        if (good) begin
            last_wr = '{a, ins, dat};
            exp_q.push_back(last_wr);
            exp_fc = (exp_fc == 255) ? 255 : exp_fc + 1;
        end else begin
            exp_err = 1;
        end
    endtask

    task automatic wait_ready(input string tag);
        bit ok = 0;
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (in_ready && !writeEnable) ok = 1;
            else step();
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s wait_ready in_ready=%b we=%b", tag, in_ready, writeEnable);
        end
    endtask

    // Scoreboard: drains observed vs. expected writes and compares flags.
    task automatic scoreboard(input string tag);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s write_count got=%0d want=%0d", tag, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            wr_t o = obs_q.pop_front();
            wr_t e = exp_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL %s write got=%h want=%h", tag, o, e);
            end
        end
        obs_q.delete();
        exp_q.delete();
        vectors++;
        if ({frame_count, frame_err, load_done} !== {8'(exp_fc), exp_err, exp_done}) begin
            miscompares++;
            $display("FAIL %s flags fc/err/done got=%0d/%b/%b want=%0d/%b/%b", tag,
                     frame_count, frame_err, load_done, exp_fc, exp_err, exp_done);
        end
        vectors++;
        if ({instructionAddress, instruction, data} !== last_wr) begin
            miscompares++;
            $display("FAIL %s held_outputs got=%h want=%h", tag,
                     {instructionAddress, instruction, data}, last_wr);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({instruction, data, instructionAddress, dataAddress, writeEnable,
             load_done, frame_err, frame_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got nonzero instr=%h data=%h fc=%0d", instruction, data, frame_count);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_single();
        send_frame(7'h05, 32'h2022_1820, 32'h0000_000A, 1);
        wait_ready("single");
        scoreboard("single");
    endtask

    task automatic test_back_to_back();
        send_frame(7'h00, 32'hDEAD_BEEF, 32'h1234_5678, 1);
        send_frame(7'h7F, 32'hCAFE_F00D, 32'h8765_4321, 1);
        wait_ready("b2b");
        scoreboard("b2b");
    endtask

    task automatic test_random();
        bubbles = 1;
        for (int n = 0; n < 20; n++) send_frame(7'($urandom), $urandom, $urandom, 1);
        bubbles = 0;
        wait_ready("random");
        scoreboard("random");
    endtask

    task automatic test_timeout();
        send_byte(8'h83);
        send_byte(8'h11);
        send_byte(8'h22);
        in_valid = 1'b0;
        repeat (TIMEOUT - 24) step();
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early frame_err=%b want=0", frame_err);
        end
        repeat (40) step();
        exp_err = 1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_in_ready got=%b want=1", in_ready);
        end
        scoreboard("timeout");
        send_frame(7'h03, 32'hA5A5_0001, 32'h5A5A_0002, 1);
        wait_ready("after_timeout");
        scoreboard("after_timeout");
    endtask

    task automatic test_reset_mid_strobe();
        bit seen = 0;
        send_frame(7'h2A, 32'h0BAD_CAFE, 32'h0000_0042, 1);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (writeEnable) seen = 1;
            else step();
        end
        do_reset();
        vectors++;
        if (!seen || writeEnable !== 1'b0 || frame_count !== 8'd0 || in_ready !== 1'b1 ||
            instruction !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_strobe_reset seen=%b we=%b fc=%0d in_ready=%b instr=%h",
                     seen, writeEnable, frame_count, in_ready, instruction);
        end
        send_frame(7'h11, 32'h1111_2222, 32'h3333_4444, 1);
        wait_ready("post_reset");
        scoreboard("post_reset");
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 260; n++) send_frame(7'($urandom), $urandom, $urandom, 1);
        wait_ready("saturate");
        scoreboard("saturate");
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        send_frame(7'h01, 32'h0, 32'h1, 1);
        wait_ready("csum_good");
        scoreboard("csum_good");
        send_frame(7'h01, 32'h0, 32'h1, 0);
        wait_ready("csum_bad");
        scoreboard("csum_bad");
    endtask
`endif

    task automatic test_end_marker();
        send_byte(8'h00);
        exp_done = 1;
        in_byte = 8'h85;
        in_valid = 1'b1;
        repeat (12) step();
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL done_in_ready got=%b want=0", in_ready);
        end
        scoreboard("end_marker");
        do_reset();
        vectors++;
        if ({load_done, frame_err, frame_count, writeEnable, instruction, data,
             instructionAddress} !== '0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL done_reset done=%b err=%b fc=%0d in_ready=%b",
                     load_done, frame_err, frame_count, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid_strobe();
        test_saturation();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_end_marker();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
